// File: rtl/miner_sequencer_if.sv
// rtl/miner_sequencer_if.sv - golden-nonce readout handshake bundle
//
// Purpose: carries the golden-nonce FIFO head to the readout path (UART/JTAG).
// Signals:
//   golden_valid  FIFO not empty (driven by the sequencer)
//   golden_ready  readout accepts the head entry (driven by the reader)
//   golden_nonce  FIFO head entry (driven by the sequencer)
// Modports: master = sequencer side, slave = readout side.

interface miner_sequencer_if;
  logic        golden_valid;
  logic        golden_ready;
  logic [31:0] golden_nonce;

  modport master (
    output golden_valid,
    output golden_nonce,
    input  golden_ready
  );

  modport slave (
    input  golden_valid,
    input  golden_nonce,
    output golden_ready
  );
endinterface

// File: rtl/miner_sequencer.sv
// rtl/miner_sequencer.sv - slot/nonce sequencer and golden-nonce matcher for a double-SHA-256 core
//
// Purpose: drives cnt/feedback/nonce into the hashing core, matches each final
// hash back to the nonce issued HASH_LAG slots earlier, and queues golden nonces
// in a small FIFO for the readout path.
// Parameters: LOOP (cycles per hash slot), HASH_LAG (slots of core latency),
//   FIFO_DEPTH (golden-nonce entries, power of two 2..16).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   run             advance cnt/nonce when high, hold when low
//   work_load       one-cycle pulse, reload nonce from nonce_base
//   nonce_base      starting nonce for new work
//   cnt, feedback   round-group index and feedback select to the core
//   nonce           nonce for the slot currently being loaded
//   hash_in         final hash; only bits [255:224] are examined
//   golden          readout handshake (miner_sequencer_if.master)
//   fifo_level      entries held, 0..FIFO_DEPTH
//   overflow        sticky, a golden nonce was dropped
//   nonce_wrap      one-cycle pulse after nonce wraps FFFFFFFF->0
// Option: define SEQ_SHARE_MASK_EN to add input share_mask[31:0], which selects
//   the hash bits that must be zero (share difficulty); otherwise all 32 bits.

module miner_sequencer #(
  parameter int unsigned LOOP       = 4,
  parameter int unsigned HASH_LAG   = 68,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    work_load,
  input  logic [31:0]             nonce_base,
  output logic [5:0]              cnt,
  output logic                    feedback,
  output logic [31:0]             nonce,
  input  logic [255:0]            hash_in,
`ifdef SEQ_SHARE_MASK_EN
  input  logic [31:0]             share_mask,
`endif
  miner_sequencer_if.master       golden,
  output logic [4:0]              fifo_level,
  output logic                    overflow,
  output logic                    nonce_wrap
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [5:0]  CNT_LAST = 6'(LOOP - 1);
  localparam logic [15:0] LAG      = 16'(HASH_LAG);
  localparam logic [4:0]  DEPTH    = 5'(FIFO_DEPTH);

  logic [15:0]   warm;
  logic          boundary;
  logic          check_en;
  logic [31:0]   mask;
  logic          hit;
  logic          push_pend;
  logic [31:0]   push_data;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    level;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          unused_hash;

  // Only the top word of the hash decides golden-ness.
  assign unused_hash = ^hash_in[223:0];

`ifdef SEQ_SHARE_MASK_EN
  assign mask = share_mask;
`else
  assign mask = 32'hFFFF_FFFF;
`endif

  assign feedback = (cnt != 6'd0);
  assign boundary = run && (cnt == CNT_LAST);
  assign check_en = (warm == LAG);
  assign hit      = run && (cnt == 6'd0) && check_en && ((hash_in[255:224] & mask) == 32'd0);

  // Slot counter, nonce and warm-up counter. work_load wins over the boundary
  // so a reload landing on the last cycle of a slot still starts cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 6'd0;
      nonce      <= 32'd0;
      warm       <= 16'd0;
      nonce_wrap <= 1'b0;
    end else if (work_load) begin
      cnt        <= 6'd0;
      nonce      <= nonce_base;
      warm       <= 16'd0;
      nonce_wrap <= 1'b0;
    end else begin
      nonce_wrap <= boundary && (nonce == 32'hFFFF_FFFF);
      if (run) begin
        cnt <= boundary ? 6'd0 : cnt + 6'd1;
      end
      if (boundary) begin
        nonce <= nonce + 32'd1;
        if (warm != LAG) begin
          warm <= warm + 16'd1;
        end
      end
    end
  end

  // The hash on hash_in at slot start belongs to the nonce issued HASH_LAG
  // slots ago; the subtraction is modular so it is correct across a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_pend <= 1'b0;
      push_data <= 32'd0;
    end else begin
      push_pend <= hit;
      push_data <= nonce - 32'(HASH_LAG);
    end
  end

  assign full  = (level == DEPTH);
  assign pop   = golden.golden_valid && golden.golden_ready;
  // A pop in the same cycle frees the slot the push writes into, even at full.
  assign wr_en = push_pend && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= 5'd0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
      if (push_pend && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign golden.golden_valid = (level != 5'd0);
  assign golden.golden_nonce = mem[rd_ptr];
  assign fifo_level          = level;

endmodule

// File: tb/tb_miner_sequencer.sv
// tb/tb_miner_sequencer.sv - directed self-checking bench for miner_sequencer

module tb_miner_sequencer;

  logic         clk;
  logic         reset;
  logic         run;
  logic         work_load;
  logic [31:0]  nonce_base;
  logic [5:0]   cnt;
  logic         feedback;
  logic [31:0]  nonce;
  logic [31:0]  hash_top;
  logic [255:0] hash_in;
  logic [4:0]   fifo_level;
  logic         overflow;
  logic         nonce_wrap;
`ifdef SEQ_SHARE_MASK_EN
  logic [31:0]  share_mask;
`endif

  int tests_run;
  int tests_failed;

  miner_sequencer_if gif ();

  assign hash_in = {hash_top, {7{32'hA5A5_5A5A}}};

  miner_sequencer #(
    .LOOP       (4),
    .HASH_LAG   (68),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .work_load  (work_load),
    .nonce_base (nonce_base),
    .cnt        (cnt),
    .feedback   (feedback),
    .nonce      (nonce),
    .hash_in    (hash_in),
`ifdef SEQ_SHARE_MASK_EN
    .share_mask (share_mask),
`endif
    .golden     (gif),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .nonce_wrap (nonce_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a hash top word for exactly one slot-start cycle.
  task automatic hit(input logic [31:0] word);
    hash_top = word;
    tick();
    hash_top = 32'h8000_0000;
  endtask

  task automatic load(input logic [31:0] base);
    nonce_base = base;
    work_load  = 1'b1;
    tick();
    work_load  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    advance(2);
    tests_run++; if (cnt !== 6'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    tests_run++; if (feedback !== 1'b0) begin tests_failed++; $display("FAIL reset_feedback: got %b expected 0", feedback); end
    tests_run++; if (nonce !== 32'd0) begin tests_failed++; $display("FAIL reset_nonce: got %h expected 0", nonce); end
    tests_run++; if (gif.golden_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", gif.golden_valid); end
    tests_run++; if (gif.golden_nonce !== 32'd0) begin tests_failed++; $display("FAIL reset_gnonce: got %h expected 0", gif.golden_nonce); end
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    tests_run++; if (nonce_wrap !== 1'b0) begin tests_failed++; $display("FAIL reset_wrap: got %b expected 0", nonce_wrap); end
    reset = 1'b0;
  endtask

  task automatic test_slot_counter();
    run = 1'b0;
    load(32'h0000_0100);
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tests_run++; if (cnt !== 6'(i % 4)) begin tests_failed++; $display("FAIL slot_cnt[%0d]: got %0d expected %0d", i, cnt, i % 4); end
      tests_run++; if (feedback !== ((i % 4) != 0)) begin tests_failed++; $display("FAIL slot_feedback[%0d]: got %b expected %b", i, feedback, (i % 4) != 0); end
      tests_run++; if (nonce !== 32'h100 + 32'(i / 4)) begin tests_failed++; $display("FAIL slot_nonce[%0d]: got %h expected %h", i, nonce, 32'h100 + 32'(i / 4)); end
      tick();
    end
    run = 1'b0;
    advance(2);
    tests_run++; if (cnt !== 6'd1) begin tests_failed++; $display("FAIL hold_cnt: got %0d expected 1", cnt); end
    tests_run++; if (nonce !== 32'h102) begin tests_failed++; $display("FAIL hold_nonce: got %h expected 102", nonce); end
    run = 1'b1;
  endtask

  task automatic test_warmup();
    load(32'h0000_0100);
    advance(40);
    hit(32'h0000_0000);
    tick();
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL warmup_level: got %0d expected 0", fifo_level); end
    tests_run++; if (gif.golden_valid !== 1'b0) begin tests_failed++; $display("FAIL warmup_valid: got %b expected 0", gif.golden_valid); end
  endtask

  task automatic test_golden();
    load(32'h0000_0100);
    advance(272);
    tests_run++; if (nonce !== 32'h144) begin tests_failed++; $display("FAIL golden_issue_nonce: got %h expected 144", nonce); end
    hit(32'h0000_0000);
    tick();
    tests_run++; if (gif.golden_valid !== 1'b1) begin tests_failed++; $display("FAIL golden_valid: got %b expected 1", gif.golden_valid); end
    tests_run++; if (gif.golden_nonce !== 32'h100) begin tests_failed++; $display("FAIL golden_nonce: got %h expected 100", gif.golden_nonce); end
    tests_run++; if (fifo_level !== 5'd1) begin tests_failed++; $display("FAIL golden_level: got %0d expected 1", fifo_level); end
    gif.golden_ready = 1'b1;
    tick();
    gif.golden_ready = 1'b0;
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL golden_pop_level: got %0d expected 0", fifo_level); end
    tick();
    hit(32'h0000_0001);
    tick();
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL near_miss_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_overflow();
    logic [31:0] expq [4];
    expq[0] = 32'h201; expq[1] = 32'h202; expq[2] = 32'h203; expq[3] = 32'h205;
    gif.golden_ready = 1'b0;
    load(32'h0000_0200);
    advance(272);
    for (int k = 0; k < 5; k++) begin
      hit(32'h0000_0000);
      advance(3);
    end
    tests_run++; if (fifo_level !== 5'd4) begin tests_failed++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    hit(32'h0000_0000);
    tests_run++; if (gif.golden_nonce !== 32'h200) begin tests_failed++; $display("FAIL ovf_head: got %h expected 200", gif.golden_nonce); end
    gif.golden_ready = 1'b1;
    tick();
    gif.golden_ready = 1'b0;
    tests_run++; if (fifo_level !== 5'd4) begin tests_failed++; $display("FAIL full_pushpop_level: got %0d expected 4", fifo_level); end
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (gif.golden_nonce !== expq[k]) begin tests_failed++; $display("FAIL drain[%0d]: got %h expected %h", k, gif.golden_nonce, expq[k]); end
      gif.golden_ready = 1'b1;
      tick();
      gif.golden_ready = 1'b0;
    end
    tests_run++; if (gif.golden_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_valid: got %b expected 0", gif.golden_valid); end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    load(32'hFFFF_FFFE);
    for (int i = 0; i < 12; i++) begin
      tests_run++; if (nonce !== 32'hFFFF_FFFE + 32'(i / 4)) begin tests_failed++; $display("FAIL wrap_nonce[%0d]: got %h expected %h", i, nonce, 32'hFFFF_FFFE + 32'(i / 4)); end
      tests_run++; if (nonce_wrap !== (i == 8)) begin tests_failed++; $display("FAIL wrap_pulse[%0d]: got %b expected %b", i, nonce_wrap, i == 8); end
      if (nonce_wrap === 1'b1) pulses++;
      tick();
    end
    tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL wrap_pulse_count: got %0d expected 1", pulses); end
    advance(260);
    hit(32'h0000_0000);
    tick();
    tests_run++; if (gif.golden_nonce !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL wrap_candidate: got %h expected fffffffe", gif.golden_nonce); end
    gif.golden_ready = 1'b1;
    tick();
    gif.golden_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    tests_run++; if (cnt !== 6'd3) begin tests_failed++; $display("FAIL b2b_setup_cnt: got %0d expected 3", cnt); end
    load(32'h0000_5000);
    tests_run++; if (nonce !== 32'h5000) begin tests_failed++; $display("FAIL b2b_nonce: got %h expected 5000", nonce); end
    tests_run++; if (cnt !== 6'd0) begin tests_failed++; $display("FAIL b2b_cnt: got %0d expected 0", cnt); end
    hit(32'h0000_0000);
    tick();
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL b2b_warm_level: got %0d expected 0", fifo_level); end
    advance(2);
    advance(268);
  endtask

  task automatic test_share_mask();
`ifdef SEQ_SHARE_MASK_EN
    share_mask = 32'hFFFF_0000;
`endif
    hit(32'h0000_ABCD);
`ifdef SEQ_SHARE_MASK_EN
    share_mask = 32'hFFFF_FFFF;
`endif
    tick();
`ifdef SEQ_SHARE_MASK_EN
    tests_run++; if (fifo_level !== 5'd1) begin tests_failed++; $display("FAIL share_level: got %0d expected 1", fifo_level); end
    tests_run++; if (gif.golden_nonce !== 32'h5000) begin tests_failed++; $display("FAIL share_nonce: got %h expected 5000", gif.golden_nonce); end
`else
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL share_level: got %0d expected 0", fifo_level); end
`endif
    gif.golden_ready = 1'b1;
    tick();
    gif.golden_ready = 1'b0;
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL share_pop_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_reset_mid();
    tick();
    hit(32'h0000_0000);
    tick();
    tests_run++; if (gif.golden_nonce !== 32'h5001) begin tests_failed++; $display("FAIL mid_nonce: got %h expected 5001", gif.golden_nonce); end
    tests_run++; if (gif.golden_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_valid: got %b expected 1", gif.golden_valid); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    advance(2);
    hit(32'h0000_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (gif.golden_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", gif.golden_valid); end
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    tests_run++; if (nonce !== 32'd0) begin tests_failed++; $display("FAIL rst_nonce: got %h expected 0", nonce); end
    tick();
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL rst_pending_lost: got %0d expected 0", fifo_level); end
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    run              = 1'b0;
    work_load        = 1'b0;
    nonce_base       = 32'd0;
    hash_top         = 32'h8000_0000;
    gif.golden_ready = 1'b0;
`ifdef SEQ_SHARE_MASK_EN
    share_mask       = 32'hFFFF_FFFF;
`endif
    test_reset();
    test_slot_counter();
    test_warmup();
    test_golden();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_share_mask();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/miner_sequencer.md
Name: miner_sequencer

Overview:
- Control stage that drives the sequencing inputs of the double-SHA-256 hashing core.
- Generates the round counter, the feedback select and the per-hash nonce.
- Consumes the final hash word and matches each golden result back to the nonce that produced it.
- Buffers golden nonces in a small FIFO for the readout path (UART/JTAG) via a valid/ready handshake.

Parameters:
- LOOP, 6'd4, cycles per hash slot; power of two, 1..64; must equal the core's LOOP.
- HASH_LAG, 16'd68, hash slots between a nonce being issued and its final hash appearing on hash_in.
- FIFO_DEPTH, 4, golden-nonce FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = advance nonces; 0 = hold nonce/cnt (hashing stalls logically)
- work_load  in  1  single-cycle pulse: new work; reload nonce from nonce_base
- nonce_base  in  32  starting nonce for new work
- cnt  out  6  round-group index to core, 0..LOOP-1
- feedback  out  1  to core; 0 = load fresh input, 1 = iterate
- nonce  out  32  nonce for the hash slot currently being loaded
- hash_in  in  256  final hash from second transform; bits [255:224] examined
- golden_valid  out  1  FIFO not empty
- golden_ready  in  1  readout accepts head entry
- golden_nonce  out  32  FIFO head
- fifo_level  out  5  entries held, 0..FIFO_DEPTH
- overflow  out  1  sticky: golden nonce dropped
- nonce_wrap  out  1  one-cycle pulse when nonce wraps FFFFFFFF->0

Behaviour:
- Reset values: cnt=0, feedback=0, nonce=0, golden_valid=0, golden_nonce=0, fifo_level=0, overflow=0, nonce_wrap=0, warm-up counter=0, FIFO pointers=0.
- Slot counter: when run=1, cnt increments each cycle and wraps LOOP-1 -> 0. When run=0, cnt holds. For LOOP=1, cnt is always 0.
- feedback is combinational: (cnt != 0). For LOOP=1, feedback is always 0.
- Slot boundary: a cycle with run=1 and cnt==LOOP-1.
  - At a slot boundary, nonce <= nonce+1 (mod 2^32).
  - If the old nonce was FFFFFFFF, nonce_wrap pulses in the following cycle.
- work_load has priority over run and the slot boundary. Next cycle: nonce=nonce_base, cnt=0, warm-up counter=0.
- Warm-up counter: saturating count of slot boundaries since load/reset, saturates at HASH_LAG. Golden checks are enabled only when the count equals HASH_LAG. This suppresses stale hashes of prior work still in flight in the core.
- Golden check: evaluated on cycles with run=1 and cnt==0 and checks enabled.
  - golden = (hash_in[255:224] & mask) == 0.
  - Candidate nonce = nonce - HASH_LAG, 32-bit modular (wraps correctly across 0).
  - golden=1 pushes the candidate into the FIFO one cycle later.
- FIFO:
  - Pop when golden_valid && golden_ready.
  - golden_nonce = head entry, registered, stable while golden_valid=1 and not popped.
  - Push+pop in the same cycle: level unchanged, no drop, even when full.
  - Push when full without pop: entry dropped, overflow <= 1.
  - overflow is cleared only by reset; work_load does not clear it.
  - Pop when empty is ignored.
  - work_load does not flush the FIFO; entries already found stay valid for the readout.
- Reset asserted mid-operation: all state returns to reset values on the next edge, FIFO contents are discarded, and any push pending that cycle is lost.

Optional Feature:
- SEQ_SHARE_MASK_EN:
  - Defined: adds input share_mask[31:0]; mask = share_mask, sampled on each check cycle. Allows lower-difficulty shares for pool reporting.
  - Undefined: no port; mask = 32'hFFFFFFFF (full-word zero test only).

Test Plan:
- Reset, LOOP=4, run=1, nonce_base=0x100 loaded -> cnt cycles 0,1,2,3,0; feedback 0,1,1,1,0; nonce increments every 4 cycles (0x100, 0x101, ...).
- After HASH_LAG slots with nonce=0x100+HASH_LAG, drive hash_in[255:224]=0 at cnt==0 -> FIFO receives 0x100; golden_valid=1, golden_nonce=0x100, fifo_level=1.
- hash_in[255:224]=0 during warm-up (slot 10 after work_load) -> no push, fifo_level stays 0.
- golden_ready=0, five golden hits with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, first four nonces drained in order. Then, at full, a simultaneous hit and pop -> level stays 4, no further drop.
- nonce_base=0xFFFFFFFE, run=1 -> nonce FFFFFFFE, FFFFFFFF, 00000000; nonce_wrap pulses once. A golden check at nonce=0x00000002 with HASH_LAG=4 yields candidate 0xFFFFFFFE.
- work_load and a slot boundary in the same cycle -> nonce=nonce_base, cnt=0 next cycle. Reset with golden_valid=1 -> golden_valid=0, fifo_level=0, overflow=0 next cycle.
- With SEQ_SHARE_MASK_EN: share_mask=0xFFFF0000, hash word 0x0000ABCD -> push; without the macro, the same word -> no push.
